// File: rtl/pps_sync_pkg.sv
// Shared types and helpers for the PPS sync controller: FSM state encoding,
// counter widths and the interval acceptance-window bounds.
package pps_sync_pkg;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        ACQUIRE  = 3'd1,
        LOCKED   = 3'd2,
        HOLDOVER = 3'd3,
        FAULT    = 3'd4
    } state_e;

    localparam int GOOD_W = 4;  // holds LOCK_COUNT up to 15
    localparam int HOLD_W = 8;  // holds HOLDOVER_MAX up to 255

    function automatic longint lo_bound(input longint freq, input longint tol);
        return freq - tol;
    endfunction

    function automatic longint hi_bound(input longint freq, input longint tol);
        return freq + tol;
    endfunction

endpackage

// File: rtl/pps_edge_detect.sv
// Brings raw PPS into clk_in, and produces a one-cycle rising-edge strobe.
// With PPS_DEGLITCH_EN defined, the strobe waits for DEGLITCH_CYCLES of stable high.
module pps_edge_detect
`ifdef PPS_DEGLITCH_EN
#(
    parameter int DEGLITCH_CYCLES = 8
)
`endif
(
    input  logic clk_in,
    input  logic reset,
    input  logic pps,
    output logic strobe
);

    logic [1:0] sync_q, sync_d;

    always_comb sync_d = {sync_q[0], pps};

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= sync_d;
    end

`ifdef PPS_DEGLITCH_EN
    localparam int HC_W = $clog2(DEGLITCH_CYCLES + 2);
    localparam logic [HC_W-1:0] HC_HIT = HC_W'(DEGLITCH_CYCLES);

    logic [HC_W-1:0] hi_cnt_q, hi_cnt_d;

    // Run length of synchronized high; parks one past the hit value so a long pulse strobes once.
    always_comb begin
        hi_cnt_d = '0;
        if (sync_q[1]) hi_cnt_d = (hi_cnt_q > HC_HIT) ? hi_cnt_q : hi_cnt_q + 1'b1;
    end

    assign strobe = sync_q[1] && (hi_cnt_q == HC_HIT);

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) hi_cnt_q <= '0;
        else       hi_cnt_q <= hi_cnt_d;
    end
`else
    logic prev_q, prev_d;

    always_comb prev_d = sync_q[1];

    assign strobe = sync_q[1] & ~prev_q;

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) prev_q <= 1'b0;
        else       prev_q <= prev_d;
    end
`endif

endmodule

// File: rtl/pps_sync_controller.sv
// Qualifies GPS PPS intervals, tracks lock/holdover/fault and drives pps_qual to the sampler.
// Optional macro PPS_DEGLITCH_EN enables a stable-high filter in pps_edge_detect.
module pps_sync_controller #(
    parameter int SYS_CLK_FREQ = 25_000_000,
    parameter int TOL_CYCLES   = 2500,
    parameter int LOCK_COUNT   = 4,
    parameter int HOLDOVER_MAX = 60,
    parameter int CNT_W        = 32
`ifdef PPS_DEGLITCH_EN
    ,
    parameter int DEGLITCH_CYCLES = 8
`endif
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             pps,
    output logic             pps_qual,
    output logic             sampler_en,
    output logic [CNT_W-1:0] period,
    output logic             locked,
    output logic             holdover,
    output logic             fault
);
    import pps_sync_pkg::*;

    localparam logic [CNT_W-1:0]  LO_B   = CNT_W'(lo_bound(SYS_CLK_FREQ, TOL_CYCLES));
    localparam logic [CNT_W-1:0]  HI_B   = CNT_W'(hi_bound(SYS_CLK_FREQ, TOL_CYCLES));
    localparam logic [CNT_W-1:0]  TMO_B  = CNT_W'(hi_bound(SYS_CLK_FREQ, TOL_CYCLES) + 1);
    localparam logic [CNT_W-1:0]  NOM_B  = CNT_W'(SYS_CLK_FREQ);
    localparam logic [GOOD_W-1:0] LOCK_N = GOOD_W'(LOCK_COUNT);
    localparam logic [HOLD_W-1:0] HOLD_N = HOLD_W'(HOLDOVER_MAX);

    logic strobe;

    pps_edge_detect
`ifdef PPS_DEGLITCH_EN
        #(.DEGLITCH_CYCLES(DEGLITCH_CYCLES))
`endif
        u_edge (
        .clk_in (clk_in),
        .reset  (reset),
        .pps    (pps),
        .strobe (strobe)
    );

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  period_q, period_d;
    logic [GOOD_W-1:0] good_q, good_d, good_inc;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              qual_q, qual_d;
    logic              samp_q, samp_d;
    logic              locked_q, locked_d;
    logic              hold_st_q, hold_st_d;
    logic              fault_q, fault_d;
    logic              in_win;

    assign in_win   = (cnt_q >= LO_B) && (cnt_q <= HI_B);
    assign good_inc = good_q + 1'b1;

    // Every issued pulse, true or synthetic, restarts the interval counter, so in
    // holdover both the synthetic cadence and a returning edge are measured from the last pulse.
    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
        period_d = period_q;
        good_d   = good_q;
        hold_d   = hold_q;
        qual_d   = 1'b0;
        if (strobe) cnt_d = CNT_W'(1);

        unique case (state_q)
            IDLE: begin
                if (strobe) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                end
            end
            ACQUIRE: begin
                if (strobe) begin
                    if (in_win) begin
                        period_d = cnt_q;
                        good_d   = good_inc;
                        if (good_inc == LOCK_N) state_d = LOCKED;
                    end else begin
                        good_d = '0;
                    end
                end else if (cnt_q >= TMO_B) begin
                    state_d = IDLE;
                end
            end
            LOCKED: begin
                if (strobe) begin
                    if (in_win) begin
                        period_d = cnt_q;
                        qual_d   = 1'b1;
                    end else begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end else if (cnt_q >= TMO_B) begin
                    state_d = HOLDOVER;
                    qual_d  = 1'b1;
                    hold_d  = HOLD_W'(1);
                    cnt_d   = CNT_W'(1);
                end
            end
            HOLDOVER: begin
                if (strobe) begin
                    hold_d = '0;
                    if (in_win) begin
                        state_d  = LOCKED;
                        period_d = cnt_q;
                        qual_d   = 1'b1;
                    end else begin
                        state_d = ACQUIRE;
                        good_d  = '0;
                    end
                end else if (cnt_q >= NOM_B) begin
                    if (hold_q == HOLD_N) begin
                        state_d = FAULT;
                    end else begin
                        qual_d = 1'b1;
                        hold_d = hold_q + 1'b1;
                        cnt_d  = CNT_W'(1);
                    end
                end
            end
            FAULT: begin
                if (strobe) begin
                    state_d = ACQUIRE;
                    good_d  = '0;
                    hold_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase

        samp_d    = (state_d == LOCKED) || (state_d == HOLDOVER);
        locked_d  = (state_d == LOCKED);
        hold_st_d = (state_d == HOLDOVER);
        fault_d   = (state_d == FAULT);
    end

    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            period_q  <= '0;
            good_q    <= '0;
            hold_q    <= '0;
            qual_q    <= 1'b0;
            samp_q    <= 1'b0;
            locked_q  <= 1'b0;
            hold_st_q <= 1'b0;
            fault_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            period_q  <= period_d;
            good_q    <= good_d;
            hold_q    <= hold_d;
            qual_q    <= qual_d;
            samp_q    <= samp_d;
            locked_q  <= locked_d;
            hold_st_q <= hold_st_d;
            fault_q   <= fault_d;
        end
    end

    assign pps_qual   = qual_q;
    assign sampler_en = samp_q;
    assign period     = period_q;
    assign locked     = locked_q;
    assign holdover   = hold_st_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_pps_sync_controller.sv
// Randomized bench for pps_sync_controller: an event-level model predicts every pps_qual
// (cycle and period) into a queue that a monitor drains; state is compared at checkpoints.
module tb_pps_sync_controller;

    localparam int FREQ = 1000;
    localparam int TOL  = 10;
    localparam int LOCK = 3;
    localparam int HMAX = 2;
    localparam int CW   = 32;
    localparam int LO   = FREQ - TOL;
    localparam int HI   = FREQ + TOL;
`ifdef PPS_DEGLITCH_EN
    localparam int LAT  = 3 + 8;
`else
    localparam int LAT  = 3;
`endif

    localparam int M_IDLE = 0, M_ACQ = 1, M_LOCK = 2, M_HOLD = 3, M_FAULT = 4;

    typedef struct {
        int          t;
        logic [31:0] per;
    } exp_t;

    logic          clk   = 1'b0;
    logic          reset = 1'b1;
    logic          pps   = 1'b0;
    logic          pps_qual, sampler_en, locked, holdover, fault;
    logic [CW-1:0] period;

    int cyc       = 0;
    int checks    = 0;
    int errors    = 0;
    int last_rise = 0;

    int          m_st     = M_IDLE;
    int          m_ref    = 0;
    int          m_good   = 0;
    int          m_hold   = 0;
    logic [31:0] m_period = '0;
    exp_t        q[$];

    pps_sync_controller #(
        .SYS_CLK_FREQ (FREQ),
        .TOL_CYCLES   (TOL),
        .LOCK_COUNT   (LOCK),
        .HOLDOVER_MAX (HMAX),
        .CNT_W        (CW)
    ) dut (
        .clk_in     (clk),
        .reset      (reset),
        .pps        (pps),
        .pps_qual   (pps_qual),
        .sampler_en (sampler_en),
        .period     (period),
        .locked     (locked),
        .holdover   (holdover),
        .fault      (fault)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push(input int t);
        q.push_back(exp_t'{t, m_period});
    endtask

    // Apply every timeout / synthetic-pulse event strictly before time t (no edge in between).
    task automatic model_advance(input int t);
        bit busy;
        busy = 1'b1;
        while (busy) begin
            busy = 1'b0;
            if (m_st == M_ACQ && m_ref + HI + 1 < t) begin
                m_st = M_IDLE;
            end else if (m_st == M_LOCK && m_ref + HI + 1 < t) begin
                m_ref  = m_ref + HI + 1;
                push(m_ref);
                m_hold = 1;
                m_st   = M_HOLD;
                busy   = 1'b1;
            end else if (m_st == M_HOLD && m_ref + FREQ < t) begin
                if (m_hold == HMAX) begin
                    m_st = M_FAULT;
                end else begin
                    m_ref  = m_ref + FREQ;
                    push(m_ref);
                    m_hold++;
                    busy = 1'b1;
                end
            end
        end
    endtask

    task automatic model_edge(input int t);
        int iv;
        bit good;
        iv   = t - m_ref;
        good = (iv >= LO) && (iv <= HI);
        case (m_st)
            M_IDLE, M_FAULT: begin
                m_st = M_ACQ; m_good = 0; m_hold = 0;
            end
            M_ACQ: begin
                if (good) begin
                    m_period = iv;
                    m_good++;
                    if (m_good == LOCK) m_st = M_LOCK;
                end else begin
                    m_good = 0;
                end
            end
            M_LOCK: begin
                if (good) begin
                    m_period = iv;
                    push(t);
                end else begin
                    m_st = M_ACQ; m_good = 0;
                end
            end
            default: begin
                m_hold = 0;
                if (good) begin
                    m_period = iv;
                    push(t);
                    m_st = M_LOCK;
                end else begin
                    m_st = M_ACQ; m_good = 0;
                end
            end
        endcase
        m_ref = t;
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_good = 0; m_hold = 0; m_period = '0; m_ref = 0;
    endtask

    // Raise pps gap cycles after the previous rise (or as soon as possible if already past).
    task automatic pps_at(input int gap, input int width);
        int n, e;
        n = last_rise + gap;
        if (n < cyc + 2) n = cyc + 2;
        e = n + LAT;
        model_advance(e);
        while (cyc < n) @(negedge clk);
        pps       = 1'b1;
        last_rise = n;
        model_edge(e);
        repeat (width) @(negedge clk);
        pps = 1'b0;
    endtask

    task automatic wait_quiet(input int n);
        model_advance(cyc + n + 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic check_state(input string name);
        model_advance(cyc + 1);
        chk(name, {sampler_en, locked, holdover, fault},
            {(m_st == M_LOCK || m_st == M_HOLD), m_st == M_LOCK, m_st == M_HOLD, m_st == M_FAULT});
    endtask

    task automatic relock();
        repeat (4) pps_at(FREQ, 50);
        check_state("relock");
    endtask

`ifdef PPS_DEGLITCH_EN
    task automatic glitch(input int offset, input int width);
        int n;
        n = last_rise + offset;
        while (cyc < n) @(negedge clk);
        pps = 1'b1;
        repeat (width) @(negedge clk);
        pps = 1'b0;
    endtask
`endif

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (reset) continue;
                    while (q.size() > 0 && q[0].t < cyc) begin
                        e = q.pop_front();
                        chk("missed_pulse_at", cyc, e.t);
                    end
                    if (pps_qual) begin
                        if (q.size() == 0) begin
                            chk("unexpected_pulse", 1, 0);
                        end else begin
                            e = q.pop_front();
                            chk("pulse_cycle", cyc, e.t);
                            chk("pulse_period", period, e.per);
                        end
                    end
                end
            end
            begin : stimulus
                repeat (3) @(negedge clk);
                chk("reset_flags", {pps_qual, sampler_en, locked, holdover, fault}, 0);
                chk("reset_period", period, 0);
                reset = 1'b0;
                last_rise = cyc;

                // Acquisition: 4 edges at nominal spacing lock; the 5th is the first pulse.
                pps_at(100, 50);
                repeat (3) pps_at(FREQ, 50);
                check_state("locked_after_4");
                chk("lock_period", period, FREQ);
                pps_at(FREQ, 50);

                // Tolerance limits, then one cycle outside.
                pps_at(LO, 50);
                pps_at(HI, 50);
                pps_at(HI + 1, 50);
                check_state("bad_1011");

                // Holdover then fault once synthetic seconds run out.
                relock();
                wait_quiet(1100);
                check_state("holdover");
                wait_quiet(2100);
                check_state("fault");

                // Recovery from holdover: edge 995 cycles after the timeout pulse.
                relock();
                pps_at(HI + 1 + 995, 50);
                check_state("recovered");
                chk("recovered_period", period, 995);

                // Random mix of near-nominal, missing and early edges.
                for (int i = 0; i < 12; i++) begin
                    int r, gap;
                    r = $urandom_range(0, 9);
                    if (r < 7)      gap = $urandom_range(LO - 5, HI + 5);
                    else if (r < 8) gap = $urandom_range(1900, 2100);
                    else if (r < 9) gap = 3300;
                    else            gap = 600;
                    pps_at(gap, 50);
                    check_state("rand_state");
                end

`ifdef PPS_DEGLITCH_EN
                relock();
                glitch(400, 5);
                pps_at(FREQ, 50);
                check_state("glitch_ignored");
                pps_at(FREQ, 20);
                check_state("pulse20_kept");
`endif

                // Reset mid-operation: outputs clear at once, relock needs fresh intervals.
                relock();
                wait_quiet(300);
                reset = 1'b1;
                #1;
                chk("midreset_flags", {pps_qual, sampler_en, locked, holdover, fault}, 0);
                chk("midreset_period", period, 0);
                chk("pending_before_reset", q.size(), 0);
                model_reset();
                repeat (3) @(negedge clk);
                reset = 1'b0;
                last_rise = cyc;
                pps_at(100, 50);
                pps_at(FREQ, 50);
                pps_at(FREQ, 50);
                check_state("reset_2good");
                pps_at(FREQ, 50);
                check_state("reset_relocked");
                pps_at(FREQ, 50);

                wait_quiet(20);
                chk("leftover_expected", q.size(), 0);
            end
        join_any
        disable fork;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
